// File: rtl/ddr_local_req_queue.sv
// Command queue and issue engine in front of the DDR controller local interface.
// Optional macro DDR_LQ_INIT_GATE_EN holds commands in S_IDLE until local_init_done_i.
module ddr_local_req_queue #(
  parameter int DEPTH      = 4,
  parameter int MAX_RD_OUT = 4
) (
  input  logic                     phy_clk,
  input  logic                     wb_rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [22:0]              req_adr_i,
  input  logic [31:0]              req_dat_i,
  input  logic [3:0]               req_be_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_dat_o,
  output logic                     wr_done_o,
  output logic [22:0]              local_address_o,
  output logic                     local_read_req_o,
  output logic                     local_write_req_o,
  output logic                     local_burstbegin_o,
  output logic [31:0]              local_wdata_o,
  output logic [3:0]               local_be_o,
  output logic [1:0]               local_size_o,
  input  logic                     local_ready_i,
  input  logic                     local_rdata_valid_i,
  input  logic                     local_init_done_i,
  input  logic [31:0]              local_rdata_i,
  output logic [$clog2(DEPTH):0]   q_level_o,
  output logic [3:0]               rd_pend_o,
  output logic                     rd_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 60;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [EW-1:0]   head;
  logic [EW-1:0]   iss_q;
  logic            burst_q;
  logic [3:0]      rd_pend_q;
  logic            rd_err_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_dat_q;
  logic            wr_done_q;
  logic            push, load;
  logic            gate_open, rd_room, head_ok;
  logic            iss_we, accept, rd_acc, wr_acc;

`ifdef DDR_LQ_INIT_GATE_EN
  assign gate_open = local_init_done_i;
`else
  logic unused_init_done;
  assign unused_init_done = local_init_done_i;
  assign gate_open = 1'b1;
`endif

  assign req_ready_o = (level_q != LW'(DEPTH));
  assign push        = req_valid_i & req_ready_o;
  assign head        = mem_q[rd_ptr_q];
  assign iss_we      = iss_q[59];

  // A read sitting in the issue register counts against the outstanding limit.
  assign rd_room = ({1'b0, rd_pend_q} + {4'd0, (state_q == S_REQ) & ~iss_we}) < 5'(MAX_RD_OUT);
  assign head_ok = (level_q != '0) & (head[59] | rd_room) & gate_open;

  assign accept = (state_q == S_REQ) & local_ready_i;
  assign rd_acc = accept & ~iss_we;
  assign wr_acc = accept & iss_we;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_ok) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (local_ready_i) begin
          if (head_ok) load = 1'b1;
          else         state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_we_i, req_adr_i, req_dat_i, req_be_i};
  end

  always_ff @(posedge phy_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      iss_q    <= '0;
      burst_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= load;
      level_q  <= level_q + LW'(push) - LW'(load);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        iss_q    <= head;
      end
    end
  end

  always_ff @(posedge phy_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_pend_q   <= '0;
      rd_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      rsp_valid_q <= local_rdata_valid_i;
      wr_done_q   <= wr_acc;
      if (local_rdata_valid_i) rsp_dat_q <= local_rdata_i;
      if (rd_acc && !local_rdata_valid_i) begin
        rd_pend_q <= rd_pend_q + 4'd1;
      end else if (!rd_acc && local_rdata_valid_i) begin
        if (rd_pend_q == 4'd0) rd_err_q <= 1'b1;
        else                   rd_pend_q <= rd_pend_q - 4'd1;
      end
    end
  end

  assign local_read_req_o   = (state_q == S_REQ) & ~iss_we;
  assign local_write_req_o  = (state_q == S_REQ) & iss_we;
  assign local_burstbegin_o = burst_q;
  assign local_address_o    = iss_q[58:36];
  assign local_wdata_o      = iss_q[35:4];
  assign local_be_o         = iss_q[3:0];
  assign local_size_o       = 2'b01;
  assign q_level_o          = level_q;
  assign rd_pend_o          = rd_pend_q;
  assign rd_err_o           = rd_err_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_dat_o          = rsp_dat_q;
  assign wr_done_o          = wr_done_q;

endmodule

// File: tb/tb_ddr_local_req_queue.sv
// Scoreboard bench for ddr_local_req_queue: in-order command model, outstanding-read
// counter model and read-data response queue, with directed and random stimulus.
module tb_ddr_local_req_queue;

  localparam int DEPTH = 4;
  localparam int MAXRD = 4;

  logic        phy_clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [22:0] req_adr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        rsp_valid_o, wr_done_o;
  logic [31:0] rsp_dat_o;
  logic [22:0] local_address_o;
  logic        local_read_req_o, local_write_req_o, local_burstbegin_o;
  logic [31:0] local_wdata_o;
  logic [3:0]  local_be_o;
  logic [1:0]  local_size_o;
  logic        local_ready_i = 1'b1, local_rdata_valid_i = 1'b0, local_init_done_i = 1'b1;
  logic [31:0] local_rdata_i = '0;
  logic [2:0]  q_level_o;
  logic [3:0]  rd_pend_o;
  logic        rd_err_o;

  int checks = 0;
  int errors = 0;

  ddr_local_req_queue #(.DEPTH(DEPTH), .MAX_RD_OUT(MAXRD)) dut (
    .phy_clk(phy_clk), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .wr_done_o(wr_done_o),
    .local_address_o(local_address_o), .local_read_req_o(local_read_req_o),
    .local_write_req_o(local_write_req_o), .local_burstbegin_o(local_burstbegin_o),
    .local_wdata_o(local_wdata_o), .local_be_o(local_be_o), .local_size_o(local_size_o),
    .local_ready_i(local_ready_i), .local_rdata_valid_i(local_rdata_valid_i),
    .local_init_done_i(local_init_done_i), .local_rdata_i(local_rdata_i),
    .q_level_o(q_level_o), .rd_pend_o(rd_pend_o), .rd_err_o(rd_err_o)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model state, advanced by the monitor on every falling edge.
  logic [59:0] exp_cmd[$];
  logic [31:0] exp_rsp[$];
  int          m_pend = 0;
  logic        m_err = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_wr_exp = 1'b0;
  logic        m_rsp_exp = 1'b0;
  logic [59:0] m_prev = '0;

  always @(negedge phy_clk) begin
    logic        req, acc;
    logic [59:0] cur, e;
    if (wb_rst_i) begin
      exp_cmd.delete(); exp_rsp.delete();
      m_pend = 0; m_err = 1'b0; m_hold = 1'b0; m_wr_exp = 1'b0; m_rsp_exp = 1'b0;
    end else begin
      req = local_read_req_o | local_write_req_o;
      acc = req & local_ready_i;
      cur = {local_write_req_o, local_address_o, local_wdata_o, local_be_o};
      if (local_read_req_o && local_write_req_o) chk("rd_wr_both", 1, 0);
      if (req) begin
        chk("burstbegin", local_burstbegin_o, !m_hold);
        if (m_hold) chk("held_cmd", cur, m_prev);
      end else begin
        chk("burstbegin_idle", local_burstbegin_o, 0);
      end
      if (acc) begin
        if (exp_cmd.size() == 0) chk("unexpected_cmd", cur, 0);
        else begin
          e = exp_cmd.pop_front();
          chk("cmd_we_adr", cur[59:36], e[59:36]);
          if (e[59]) chk("cmd_dat_be", cur[35:0], e[35:0]);
          else chk("rd_limit", (m_pend < MAXRD), 1);
        end
      end
      if (req_valid_i && req_ready_o)
        exp_cmd.push_back({req_we_i, req_adr_i, req_dat_i, req_be_i});
      chk("wr_done", wr_done_o, m_wr_exp);
      m_wr_exp = acc & local_write_req_o;
      chk("rsp_valid", rsp_valid_o, m_rsp_exp);
      if (rsp_valid_o && exp_rsp.size() != 0) chk("rsp_dat", rsp_dat_o, exp_rsp.pop_front());
      m_rsp_exp = local_rdata_valid_i;
      if (local_rdata_valid_i) exp_rsp.push_back(local_rdata_i);
      chk("rd_pend", rd_pend_o, m_pend);
      chk("rd_err", rd_err_o, m_err);
      if (acc && local_read_req_o && !local_rdata_valid_i) m_pend++;
      else if (!(acc && local_read_req_o) && local_rdata_valid_i) begin
        if (m_pend == 0) m_err = 1'b1; else m_pend--;
      end
      m_hold = req & ~local_ready_i;
      m_prev = cur;
    end
  end

  logic resp_en = 1'b0;

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge phy_clk); #1;
    if (resp_en) begin
      local_rdata_valid_i = (m_pend > 0) && ($urandom_range(0, 1) == 1);
      local_rdata_i = $urandom;
    end
  endtask

  task automatic push(input logic we, input logic [22:0] adr, input logic [31:0] dat, input logic [3:0] be);
    int n = 0;
    req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_be_i = be; req_valid_i = 1'b1;
    @(negedge phy_clk);
    while (!req_ready_o && n < 100) begin step(); @(negedge phy_clk); n++; end
    if (!req_ready_o) chk("push_timeout", 0, 1);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid_i = 1'b0; local_ready_i = 1'b1; resp_en = 1'b1;
    while ((exp_cmd.size() != 0 || m_pend != 0 || q_level_o != 0) && n < 300) begin step(); n++; end
    chk("drain_done", (n < 300), 1);
    resp_en = 1'b0; local_rdata_valid_i = 1'b0;
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge phy_clk);
    @(negedge phy_clk);
    chk("rst_outputs", {local_read_req_o, local_write_req_o, local_burstbegin_o, rsp_valid_o,
                        wr_done_o, rd_err_o, rd_pend_o, q_level_o, local_address_o}, 0);
    chk("rst_size", local_size_o, 2'b01);
    step(); wb_rst_i = 1'b0; step();
    chk("idle_ready", req_ready_o, 1);

    // Single write: request two cycles after the push, wr_done one cycle later.
    push(1'b1, 23'h000123, 32'hDEADBEEF, 4'hF);
    step();
    @(negedge phy_clk);
    chk("wr_lat_req", {local_write_req_o, local_burstbegin_o, local_address_o}, {2'b11, 23'h000123});
    step();
    @(negedge phy_clk);
    chk("wr_lat_done", {local_write_req_o, wr_done_o}, 2'b01);
    step();

    // Four back-to-back reads fill the outstanding budget, then return in order.
    for (int i = 0; i < 4; i++) push(1'b0, 23'(32'h100 + i), 32'h0, 4'h0);
    repeat (4) step();
    chk("rd4_pend", rd_pend_o, 4);
    for (int i = 0; i < 4; i++) begin
      local_rdata_valid_i = 1'b1; local_rdata_i = 32'hA0 + i; step();
    end
    local_rdata_valid_i = 1'b0;
    step(); step();
    chk("rd4_pend_zero", rd_pend_o, 0);

    // Fifth read stalls at the limit until one beat returns.
    for (int i = 0; i < 5; i++) push(1'b0, 23'(32'h200 + i), 32'h0, 4'h0);
    repeat (4) step();
    @(negedge phy_clk);
    chk("rd5_stall", {q_level_o, rd_pend_o, local_read_req_o}, {3'd1, 4'd4, 1'b0});
    step();
    local_rdata_valid_i = 1'b1; local_rdata_i = 32'h5A5A0001; step();
    local_rdata_valid_i = 1'b0;
    repeat (4) step();
    chk("rd5_issued", {q_level_o, rd_pend_o}, {3'd0, 4'd4});
    drain();

    // Write held by a not-ready controller, then the queue fills up.
    local_ready_i = 1'b0;
    push(1'b1, 23'h7ABCDE, 32'h12345678, 4'h5);
    repeat (4) step();
    local_ready_i = 1'b1; step(); local_ready_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push(1'b1, 23'(32'h300 + i), $urandom, 4'(i + 1));
    @(negedge phy_clk);
    chk("full", {req_ready_o, q_level_o}, {1'b0, 3'(DEPTH)});
    drain();

`ifdef DDR_LQ_INIT_GATE_EN
    local_init_done_i = 1'b0;
    push(1'b1, 23'h000400, 32'hCAFEF00D, 4'hF);
    push(1'b0, 23'h000401, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge phy_clk);
      chk("gate_closed", {local_read_req_o, local_write_req_o}, 0);
    end
    chk("gate_level", q_level_o, 2);
    local_init_done_i = 1'b1;
    drain();
    chk("gate_drained", q_level_o, 0);
`endif

    // Random traffic against the reference model.
    resp_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      req_valid_i   = ($urandom_range(0, 2) != 0);
      req_we_i      = $urandom_range(0, 1);
      req_adr_i     = 23'($urandom);
      req_dat_i     = $urandom;
      req_be_i      = 4'($urandom);
      local_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset with two reads outstanding; a late beat must flag an error.
    push(1'b0, 23'h000500, 32'h0, 4'h0);
    push(1'b0, 23'h000501, 32'h0, 4'h0);
    repeat (4) step();
    chk("pre_rst_pend", rd_pend_o, 2);
    wb_rst_i = 1'b1;
    @(negedge phy_clk);
    chk("mid_rst_outputs", {local_read_req_o, local_write_req_o, local_burstbegin_o, rsp_valid_o,
                            wr_done_o, rd_err_o, rd_pend_o, q_level_o}, 0);
    step(); wb_rst_i = 1'b0; step();
    local_rdata_valid_i = 1'b1; local_rdata_i = 32'h55AA55AA; step();
    local_rdata_valid_i = 1'b0;
    @(negedge phy_clk);
    chk("late_beat", {rd_err_o, rsp_valid_o, rd_pend_o}, {2'b11, 4'd0});
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
